// File: rtl/spi_reg_frame_ctrl.sv
// rtl/spi_reg_frame_ctrl.sv - CS_n-framed SPI register access: command byte, then data bytes.
// Frame state clears on CS_n high; the register bank clears only on i_Rst_L.
module spi_reg_frame_ctrl #(
  parameter int         NUM_REGS    = 16,
  parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
  input  logic                  w_SPI_Clk,
  input  logic                  i_Rst_L,
  input  logic                  i_SPI_CS_n,
  input  logic                  i_SPI_MOSI,
  output logic                  o_SPI_MISO,
  output logic [NUM_REGS*8-1:0] o_Regs,
  output logic                  o_Wr_Strobe,
  output logic [6:0]            o_Wr_Addr,
  output logic [7:0]            o_Wr_Data
);

  localparam logic [1:0] ST_CMD   = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;

  logic [1:0] state;
  logic [2:0] bit_cnt;
  logic [6:0] rx_shift;
  logic [7:0] tx_shift;
  logic [6:0] ptr;
  logic [7:0] regs [NUM_REGS];

  logic       byte_done;
  logic [7:0] rx_byte;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic       wr_hit;

  assign byte_done = (bit_cnt == 3'd7);
  assign rx_byte   = {rx_shift, i_SPI_MOSI};
  assign wr_hit    = byte_done && (state == ST_WRITE) && ({1'b0, ptr} < 8'(NUM_REGS));

  // Read address for the response byte loaded on this byte-complete edge
  always_comb begin
    rd_addr = (state == ST_CMD) ? rx_byte[6:0] : ptr + 7'd1;
    rd_data = 8'h00;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (rd_addr == 7'(k)) rd_data = regs[k];
    end
  end

  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L or posedge i_SPI_CS_n) begin
    if (!i_Rst_L || i_SPI_CS_n) begin
      state       <= ST_CMD;
      bit_cnt     <= 3'd0;
      rx_shift    <= 7'd0;
      tx_shift    <= STATUS_BYTE;
      ptr         <= 7'd0;
      o_Wr_Strobe <= 1'b0;
    end else begin
      rx_shift    <= rx_byte[6:0];
      bit_cnt     <= bit_cnt + 3'd1;
      o_Wr_Strobe <= wr_hit;
      if (!byte_done) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end else begin
        case (state)
          ST_CMD: begin
            ptr <= rx_byte[6:0];
            if (rx_byte[7]) begin
              state    <= ST_READ;
              tx_shift <= rd_data;
            end else begin
              state    <= ST_WRITE;
              tx_shift <= 8'h00;
            end
          end
          ST_WRITE: begin
            ptr      <= ptr + 7'd1;
            tx_shift <= 8'h00;
          end
          ST_READ: begin
            ptr      <= ptr + 7'd1;
            tx_shift <= rd_data;
          end
          default: begin
            state    <= ST_CMD;
            tx_shift <= STATUS_BYTE;
          end
        endcase
      end
    end
  end

  always_ff @(posedge w_SPI_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= 8'h00;
      o_Wr_Addr <= 7'd0;
      o_Wr_Data <= 8'h00;
    end else if (wr_hit) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        if (ptr == 7'(k)) regs[k] <= rx_byte;
      end
      o_Wr_Addr <= ptr;
      o_Wr_Data <= rx_byte;
    end
  end

  assign o_SPI_MISO = i_SPI_CS_n ? 1'b0 : tx_shift[7];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign o_Regs[8*g +: 8] = regs[g];
  end

endmodule

// File: tb/tb_spi_reg_frame_ctrl.sv
// tb/tb_spi_reg_frame_ctrl.sv - directed bench for spi_reg_frame_ctrl.
module tb_spi_reg_frame_ctrl;

  logic         clk = 1'b0;
  logic         rst_l;
  logic         cs_n;
  logic         mosi;
  logic         miso;
  logic [127:0] regs;
  logic         wr_strobe;
  logic [6:0]   wr_addr;
  logic [7:0]   wr_data;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total_cnt = 0;
  int strobe_cnt = 0;
  int strobe_base;
  logic [127:0] exp_regs;
  logic [7:0]   r;

  spi_reg_frame_ctrl #(.NUM_REGS(16), .STATUS_BYTE(8'hA5)) dut (
    .w_SPI_Clk  (clk),
    .i_Rst_L    (rst_l),
    .i_SPI_CS_n (cs_n),
    .i_SPI_MOSI (mosi),
    .o_SPI_MISO (miso),
    .o_Regs     (regs),
    .o_Wr_Strobe(wr_strobe),
    .o_Wr_Addr  (wr_addr),
    .o_Wr_Data  (wr_data)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wr_strobe === 1'b1) strobe_cnt++;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic frame_begin();
    @(negedge clk);
    cs_n = 1'b0;
  endtask

  task automatic frame_end();
    #2 cs_n = 1'b1;
    mosi = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Drives n bits MSB-first; each bit is set at a negedge and MISO is sampled just after.
  task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      mosi = tx[i];
      #1 rx[i] = miso;
      @(negedge clk);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    spi_bits(tx, 8, rx);
  endtask

  initial begin
    rst_l = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    exp_regs = '0;
    #22;
    chk("rst_regs", regs, 128'h0);
    chk("rst_strobe", wr_strobe, 1'b0);
    chk("rst_miso", miso, 1'b0);
    chk("rst_wr_addr", wr_addr, 7'h0);
    chk("rst_wr_data", wr_data, 8'h0);
    rst_l = 1'b1;
    repeat (2) @(negedge clk);

    frame_begin();
    spi_byte(8'h01, r);
    spi_byte(8'h77, r);
    frame_end();
    chk("pre_reg1", regs, 128'h7700);

    // T1: reset in the middle of a frame
    frame_begin();
    spi_byte(8'h05, r);
    spi_bits(8'hFF, 3, r);
    #1 rst_l = 1'b0;
    #1;
    chk("t1_regs", regs, 128'h0);
    chk("t1_strobe", wr_strobe, 1'b0);
    chk("t1_wr_data", wr_data, 8'h0);
    cs_n = 1'b1;
    #1;
    chk("t1_miso", miso, 1'b0);
    @(negedge clk);
    rst_l = 1'b1;
    mosi = 1'b0;
    repeat (2) @(negedge clk);

    // T2: single write
    strobe_base = strobe_cnt;
    frame_begin();
    spi_byte(8'h03, r);
    chk("t2_rx_status", r, 8'hA5);
    spi_byte(8'h5A, r);
    chk("t2_rx_data", r, 8'h00);
    frame_end();
    exp_regs[8*3 +: 8] = 8'h5A;
    chk("t2_regs", regs, exp_regs);
    chk("t2_strobes", strobe_cnt - strobe_base, 1);
    chk("t2_wr_addr", wr_addr, 7'd3);
    chk("t2_wr_data", wr_data, 8'h5A);
    chk("t2_idle_miso", miso, 1'b0);

    // T3: burst write running past the last register
    strobe_base = strobe_cnt;
    frame_begin();
    spi_byte(8'h0E, r);
    spi_byte(8'h11, r);
    spi_byte(8'h22, r);
    spi_byte(8'h33, r);
    frame_end();
    exp_regs[8*14 +: 8] = 8'h11;
    exp_regs[8*15 +: 8] = 8'h22;
    chk("t3_regs", regs, exp_regs);
    chk("t3_strobes", strobe_cnt - strobe_base, 2);
    chk("t3_wr_addr", wr_addr, 7'd15);
    chk("t3_wr_data", wr_data, 8'h22);

    // Setup for reads: reg4, reg0, reg2
    frame_begin(); spi_byte(8'h04, r); spi_byte(8'hC3, r); frame_end();
    frame_begin(); spi_byte(8'h00, r); spi_byte(8'h3C, r); frame_end();
    frame_begin(); spi_byte(8'h02, r); spi_byte(8'h9B, r); frame_end();
    exp_regs[8*4 +: 8] = 8'hC3;
    exp_regs[8*0 +: 8] = 8'h3C;
    exp_regs[8*2 +: 8] = 8'h9B;
    chk("setup_regs", regs, exp_regs);

    // T4: burst read
    strobe_base = strobe_cnt;
    frame_begin();
    spi_byte(8'h83, r);
    chk("t4_rx0", r, 8'hA5);
    spi_byte(8'hFF, r);
    chk("t4_rx1", r, 8'h5A);
    spi_byte(8'h00, r);
    chk("t4_rx2", r, 8'hC3);
    spi_byte(8'hAA, r);
    chk("t4_rx3", r, 8'h00);
    frame_end();
    chk("t4_strobes", strobe_cnt - strobe_base, 0);
    chk("t4_regs", regs, exp_regs);

    // T5: read at 127, pointer wraps to 0
    frame_begin();
    spi_byte(8'hFF, r);
    chk("t5_rx0", r, 8'hA5);
    spi_byte(8'h00, r);
    chk("t5_rx1", r, 8'h00);
    spi_byte(8'h00, r);
    chk("t5_rx2", r, 8'h3C);
    frame_end();

    // T6: aborted write, then read back
    strobe_base = strobe_cnt;
    frame_begin();
    spi_byte(8'h02, r);
    spi_bits(8'hFF, 5, r);
    frame_end();
    chk("t6_regs", regs, exp_regs);
    chk("t6_strobes", strobe_cnt - strobe_base, 0);
    frame_begin();
    spi_byte(8'h82, r);
    chk("t6_rx0", r, 8'hA5);
    spi_byte(8'h00, r);
    chk("t6_rx1", r, 8'h9B);
    frame_end();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
